mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
Memory-side initiator for the team's standard 1-cycle-latency memory interface (wraddress, rdaddress, wren, data, q). It drives that interface to copy a block of words from a source address range to a destination range, one word per cycle, fully pipelined across the 1-cycle read latency. It sits between the CPU's control registers (start/src/dst/length) and a sample or data memory. Typical uses are moving audio sample buffers and clearing frame memory.

Parameters:
width, 16, memory word width; must match the attached memory's width.
ADDR_W, 16, address width; fixed by the memory interface, do not override.

Ports:
clock  input  1  rising-edge clock shared with the memory.
reset  input  1  synchronous, active-high reset.
start  input  1  1-cycle request; sampled only while idle.
src_addr  input  16  first source word address; sampled with start.
dst_addr  input  16  first destination word address; sampled with start.
length  input  16  number of words to copy (0..65535); sampled with start.
busy  output  1  high while a transfer is in progress.
done  output  1  1-cycle pulse when a transfer completes.
rdaddress  output  16  memory read address.
wraddress  output  16  memory write address.
wren  output  1  memory write enable.
data  output  width  memory write data.
q  input  width  memory read data; it returns the word at the rdaddress presented in the previous cycle.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising clock.
- Reset values: busy=0, done=0, wren=0, rdaddress=0, wraddress=0; FSM=IDLE; counters=0.
- FSM states:
  - IDLE: waits for start.
  - RUN: issues reads and performs writes.
  - DRAIN: performs the final write after the last read.
- IDLE transitions:
  - start=1 with length!=0 -> RUN. Latch rdaddress<=src_addr, wr_base<=dst_addr, rd_left<=length.
  - start=1 with length=0 -> stay IDLE. done=1 next cycle; no memory writes.
- RUN, each cycle:
  - The read at rdaddress is in flight.
  - Next edge: rdaddress<=rdaddress+1, rd_left<=rd_left-1, wren<=1, wraddress<=dst of that read.
  - When rd_left=1 -> DRAIN.
- DRAIN: wren=1 for the last word. Next edge: wren<=0, busy<=0, done<=1 for one cycle -> IDLE.
- Write data: data is driven combinationally from q; write-stage latency is exactly 1 cycle after the read.
- Timeline, with start sampled at edge E:
  - cycle E+1: busy=1, rdaddress=src.
  - cycle E+2: wren=1, wraddress=dst, data=mem[src].
  - last write in cycle E+1+length.
  - done and busy=0 in cycle E+2+length.
  - Throughput: one word per cycle. Total busy cycles: length+1.
- wren=0 in every cycle with no valid write; data is don't-care when wren=0.
- Address arithmetic is modulo 2^16: 0xFFFF+1 wraps to 0x0000 on both read and write sides.
- start while busy is ignored (no queueing). Inputs are not re-sampled mid-transfer.
- Overlapping ranges on one memory:
  - dst<=src copies correctly (forward order).
  - dst>src within the source range gives undefined results. Software must avoid this case.
- Reset mid-transfer: at the next edge wren<=0, busy<=0, FSM=IDLE. No done pulse. Partial writes already performed remain.
- done and a new start in the same cycle: start is accepted (FSM is already IDLE).

Optional Feature:
MEM_COPY_FILL_EN
- Defined: adds inputs fill (1 bit) and fill_value (width bits), sampled with start.
  - With fill=1, no reads are issued; rdaddress holds its value.
  - data=fill_value latched at start.
  - Writes start in cycle E+1 (no read latency). done arrives in cycle E+1+length.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Shared package: FSM state encodings (IDLE, RUN, DRAIN), ADDR_W=16, default word width.
- One natural sub-module: mem_copy_addr_gen, a loadable 16-bit incrementing address counter with wrap. Instantiate it twice, once for read and once for write.

Test Plan:
- Preload mem[0x0100..0x0103]=A,B,C,D; start src=0x0100 dst=0x0200 length=4 -> wren high in 4 consecutive cycles at 0x0200..0x0203 with data A,B,C,D; done pulse 6 cycles after the start edge; busy high for 5 cycles.
- length=0 -> no wren; done=1 exactly one cycle after start; busy stays 0.
- src=0xFFFE dst=0x7FFF length=3 -> reads 0xFFFE,0xFFFF,0x0000; writes 0x7FFF,0x8000,0x8001.
- start pulsed again mid-transfer with different src -> ignored; original copy completes unchanged.
- reset asserted in the 2nd write cycle of a length=8 copy -> wren=0 next cycle; no done; only 1–2 words written; new start afterwards works normally.
- (MEM_COPY_FILL_EN) fill=1 fill_value=0x5A5A dst=0x0010 length=3 -> writes 0x5A5A at 0x0010..0x0012 in cycles E+1..E+3; done at E+4.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg: shared FSM encoding and widths for the block copy engine
// Contents: ADDR_W (memory address width), WIDTH_DEF (default word width), state_t (IDLE/RUN/DRAIN)
package mem_copy_engine_pkg;
    localparam int ADDR_W = 16;
    localparam int WIDTH_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/mem_copy_engine_addr_gen.sv
// mem_copy_addr_gen: loadable incrementing address counter, wraps modulo 2^ADDR_W
// Ports: clock, reset (sync, active-high), load/load_value (load wins over inc), inc, addr (current address)
module mem_copy_addr_gen
    import mem_copy_engine_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge clock) begin
        if (reset)
            addr <= '0;
        else if (load)
            addr <= load_value;
        else if (inc)
            addr <= addr + ADDR_W'(1);
    end
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies length words from src_addr to dst_addr over a 1-cycle-latency memory port
// Ports: clock, reset (sync, active-high); start/src_addr/dst_addr/length request (sampled only while idle);
//        busy, done (1-cycle pulse); memory side rdaddress, wraddress, wren, data (write), q (read, 1-cycle latency)
// Build option MEM_COPY_FILL_EN: adds fill/fill_value; with fill=1 writes fill_value to the destination, no reads
module mem_copy_engine #(
    parameter int width  = mem_copy_engine_pkg::WIDTH_DEF,
    parameter int ADDR_W = mem_copy_engine_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [width-1:0]  fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic [width-1:0]  data,
    input  logic [width-1:0]  q
);
    import mem_copy_engine_pkg::*;

    state_t            state, state_n;
    logic [ADDR_W-1:0] rd_left, left_n;
    logic              wren_n, done_n, rd_load, rd_inc, wr_load;
    logic              fill_go, fill_mode;
    logic              last;

`ifdef MEM_COPY_FILL_EN
    logic             fill_q;
    logic [width-1:0] fill_val_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state == IDLE && start) begin
            fill_q     <= fill;
            fill_val_q <= fill_value;
        end
    end

    assign fill_go   = fill;
    assign fill_mode = fill_q;
    assign data      = fill_mode ? fill_val_q : q;
`else
    assign fill_go   = 1'b0;
    assign fill_mode = 1'b0;
    assign data      = q;
`endif

    assign busy = state != IDLE;
    assign last = rd_left == ADDR_W'(1);

    // Write address only advances after a write has been performed, so it
    // trails the read address by exactly the memory read latency.
    mem_copy_addr_gen u_rd (
        .clock      (clock),
        .reset      (reset),
        .load       (rd_load),
        .inc        (rd_inc),
        .load_value (src_addr),
        .addr       (rdaddress)
    );

    mem_copy_addr_gen u_wr (
        .clock      (clock),
        .reset      (reset),
        .load       (wr_load),
        .inc        (wren),
        .load_value (dst_addr),
        .addr       (wraddress)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rd_left <= '0;
            wren    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            rd_left <= left_n;
            wren    <= wren_n;
            done    <= done_n;
        end
    end

    // In fill mode rd_left counts remaining writes and the DRAIN stage is
    // skipped because there is no read latency to cover.
    always_comb begin
        state_n = state;
        left_n  = rd_left;
        wren_n  = 1'b0;
        done_n  = 1'b0;
        rd_load = 1'b0;
        rd_inc  = 1'b0;
        wr_load = 1'b0;
        case (state)
            IDLE: begin
                done_n = start && length == '0;
                if (start && length != '0) begin
                    state_n = RUN;
                    left_n  = length;
                    wr_load = 1'b1;
                    rd_load = !fill_go;
                    wren_n  = fill_go;
                end
            end
            RUN: begin
                left_n  = rd_left - ADDR_W'(1);
                rd_inc  = !fill_mode;
                wren_n  = !fill_mode || !last;
                done_n  = fill_mode && last;
                state_n = !last ? RUN : fill_mode ? IDLE : DRAIN;
            end
            DRAIN: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed self-checking bench for mem_copy_engine with a 1-cycle-latency memory model
module tb_mem_copy_engine;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
    logic        busy, done, wren;
    logic [15:0] rdaddress, wraddress, data, q;
`ifdef MEM_COPY_FILL_EN
    logic        fill = 1'b0;
    logic [15:0] fill_value = '0;
`endif

    logic [15:0] mem [0:65535];
    logic [15:0] exp_d [0:7];
    logic [15:0] pre_a = '0, pre_v = '0;
    logic        pre_we = 1'b0;
    logic [15:0] wa_q[$], wd_q[$], ra_q[$];
    int          wc_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          done_cyc, done_cnt, busy_cnt;

    mem_copy_engine dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
`ifdef MEM_COPY_FILL_EN
        .fill       (fill),
        .fill_value (fill_value),
`endif
        .busy       (busy),
        .done       (done),
        .rdaddress  (rdaddress),
        .wraddress  (wraddress),
        .wren       (wren),
        .data       (data),
        .q          (q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_we)
            mem[pre_a] <= pre_v;
        else if (wren)
            mem[wraddress] <= data;
        q <= mem[rdaddress];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        @(negedge clock);
        pre_a  = a;
        pre_v  = v;
        pre_we = 1'b1;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Start sampled at edge E; sample k is taken mid-cycle E+k.
    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                       input int poke_k, input int rst_k);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        ra_q.delete();
        done_cyc = 0;
        done_cnt = 0;
        busy_cnt = 0;
        @(negedge clock);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            if (wren) begin
                wa_q.push_back(wraddress);
                wd_q.push_back(data);
                wc_q.push_back(k);
            end
            if (k <= int'(n))
                ra_q.push_back(rdaddress);
            if (busy)
                busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0)
                    done_cyc = k;
            end
            start = (k == poke_k);
            if (k == poke_k) begin
                src_addr = 16'h0500;
                dst_addr = 16'h0600;
                length   = 16'd2;
            end
            reset = (k == rst_k);
        end
    endtask

    task automatic check_wr(input string t, input int n, input logic [15:0] d, input int c0);
        check({t, " nwr"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check($sformatf("%s wa%0d", t, i), wa_q[i], d + 16'(i));
            check($sformatf("%s wd%0d", t, i), wd_q[i], exp_d[i]);
            check($sformatf("%s wc%0d", t, i), wc_q[i], c0 + i);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst wren", wren, 0);
        check("rst rdaddr", rdaddress, 0);
        check("rst wraddr", wraddress, 0);
        reset = 1'b0;

        poke(16'h0100, 16'hA1A1);
        poke(16'h0101, 16'hB2B2);
        poke(16'h0102, 16'hC3C3);
        poke(16'h0103, 16'hD4D4);
        exp_d[0] = 16'hA1A1;
        exp_d[1] = 16'hB2B2;
        exp_d[2] = 16'hC3C3;
        exp_d[3] = 16'hD4D4;
        run(16'h0100, 16'h0200, 16'd4, 0, 0);
        check_wr("t1", 4, 16'h0200, 2);
        check("t1 done_cyc", done_cyc, 6);
        check("t1 done_cnt", done_cnt, 1);
        check("t1 busy", busy_cnt, 5);
        check("t1 ra0", ra_q[0], 16'h0100);
        check("t1 mem203", mem[16'h0203], 16'hD4D4);

        run(16'h0100, 16'h0900, 16'd0, 0, 0);
        check("t2 nwr", wa_q.size(), 0);
        check("t2 done_cyc", done_cyc, 1);
        check("t2 done_cnt", done_cnt, 1);
        check("t2 busy", busy_cnt, 0);

        poke(16'hFFFE, 16'h1111);
        poke(16'hFFFF, 16'h2222);
        poke(16'h0000, 16'h3333);
        exp_d[0] = 16'h1111;
        exp_d[1] = 16'h2222;
        exp_d[2] = 16'h3333;
        run(16'hFFFE, 16'h7FFF, 16'd3, 0, 0);
        check_wr("t3", 3, 16'h7FFF, 2);
        check("t3 ra0", ra_q[0], 16'hFFFE);
        check("t3 ra1", ra_q[1], 16'hFFFF);
        check("t3 ra2", ra_q[2], 16'h0000);
        check("t3 done_cyc", done_cyc, 5);

        poke(16'h0600, 16'h0000);
        exp_d[0] = 16'hA1A1;
        exp_d[1] = 16'hB2B2;
        exp_d[2] = 16'hC3C3;
        exp_d[3] = 16'hD4D4;
        run(16'h0100, 16'h0300, 16'd4, 2, 0);
        check_wr("t4", 4, 16'h0300, 2);
        check("t4 done_cyc", done_cyc, 6);
        check("t4 done_cnt", done_cnt, 1);
        check("t4 mem600", mem[16'h0600], 16'h0000);

        poke(16'h0104, 16'h5555);
        poke(16'h0105, 16'h6666);
        poke(16'h0106, 16'h7777);
        poke(16'h0107, 16'h8888);
        poke(16'h0402, 16'h0000);
        run(16'h0100, 16'h0400, 16'd8, 0, 3);
        check_wr("t5", 2, 16'h0400, 2);
        check("t5 done_cnt", done_cnt, 0);
        check("t5 busy", busy_cnt, 3);
        check("t5 mem402", mem[16'h0402], 16'h0000);
        exp_d[0] = 16'h5555;
        exp_d[1] = 16'h6666;
        run(16'h0104, 16'h0500, 16'd2, 0, 0);
        check_wr("t5b", 2, 16'h0500, 2);
        check("t5b done_cyc", done_cyc, 4);

`ifdef MEM_COPY_FILL_EN
        fill       = 1'b1;
        fill_value = 16'h5A5A;
        for (int i = 0; i < 3; i++)
            exp_d[i] = 16'h5A5A;
        run(16'h0000, 16'h0010, 16'd3, 0, 0);
        fill = 1'b0;
        check_wr("fill", 3, 16'h0010, 1);
        check("fill done_cyc", done_cyc, 4);
        check("fill busy", busy_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
